// File: rtl/reg_file_stack_if.sv
// reg_file_stack_if
//  Bundles the register-file and stack-pointer signals of reg_file_stack.
//  master: the driver side (pipeline control). It drives the write, read and stack controls
//          and receives the read data, SP and flags.
//  slave : reg_file_stack itself.
//  Signals:
//   WrEn, W_Add, WrData  write port of the general registers
//   R_Add_A, R_Add_B     read addresses; Reg_A, Reg_B read data (combinational)
//   IncEn, DecEn         pop / push requests; FlagClr clears the sticky flags
//   Sp                   stack access address; Sp_Cur registered SP
//   Stk_Ovf, Stk_Unf     sticky wrap flags
interface reg_file_stack_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
) ();
  logic             WrEn;
  logic [ADDR-1:0]  W_Add;
  logic [WIDTH-1:0] WrData;
  logic [ADDR-1:0]  R_Add_A;
  logic [ADDR-1:0]  R_Add_B;
  logic [WIDTH-1:0] Reg_A;
  logic [WIDTH-1:0] Reg_B;
  logic             IncEn;
  logic             DecEn;
  logic             FlagClr;
  logic [WIDTH-1:0] Sp;
  logic [WIDTH-1:0] Sp_Cur;
  logic             Stk_Ovf;
  logic             Stk_Unf;

  modport master (
    output WrEn, W_Add, WrData, R_Add_A, R_Add_B, IncEn, DecEn, FlagClr,
    input  Reg_A, Reg_B, Sp, Sp_Cur, Stk_Ovf, Stk_Unf
  );

  modport slave (
    input  WrEn, W_Add, WrData, R_Add_A, R_Add_B, IncEn, DecEn, FlagClr,
    output Reg_A, Reg_B, Sp, Sp_Cur, Stk_Ovf, Stk_Unf
  );
endinterface

// File: rtl/reg_file_stack.sv
// reg_file_stack
//  Register file (DEPTH x WIDTH) with two combinational read ports, one write port and
//  optional same-cycle write-to-read forwarding, plus a clocked stack pointer with
//  pre-increment pop, post-decrement push and sticky overflow/underflow flags.
//  Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reg_file_stack_if.slave (see the interface header for the signal list)
module reg_file_stack #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter int               ADDR    = 2,
  parameter logic [WIDTH-1:0] SP_INIT = 8'hFF,
  parameter bit               BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_stack_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

  logic [WIDTH-1:0] reg_arr_r [DEPTH];
  logic [WIDTH-1:0] sp_r;
  logic             ovf_r;
  logic             unf_r;

  logic             pop_s;
  logic             push_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [WIDTH-1:0] sp_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  // Addresses at or above DEPTH do not map to a register (only possible for non-power-of-2 DEPTH).
  function automatic logic addr_ok(input logic [ADDR-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  // Decode stack requests; asserting both IncEn and DecEn is treated as no operation.
  always_comb begin
    pop_s     = bus.IncEn & ~bus.DecEn;
    push_s    = bus.DecEn & ~bus.IncEn;
    ovf_set_s = push_s & (sp_r == ZERO_C);
    unf_set_s = pop_s & (sp_r == ONES_C);
  end

  // Register array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_arr_r[i] <= ZERO_C;
      end
    end else if (bus.WrEn && addr_ok(bus.W_Add)) begin
      reg_arr_r[bus.W_Add] <= bus.WrData;
    end else begin
      reg_arr_r <= reg_arr_r;
    end
  end

  // Stack pointer and sticky flags; a wrap in the same cycle as FlagClr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r  <= SP_INIT;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (pop_s) begin
        sp_r <= sp_r + ONE_C;
      end else if (push_s) begin
        sp_r <= sp_r - ONE_C;
      end else begin
        sp_r <= sp_r;
      end

      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (bus.FlagClr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end

      if (unf_set_s) begin
        unf_r <= 1'b1;
      end else if (bus.FlagClr) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  // Stack access address: a pop addresses the slot above the current SP, a push the current SP.
  always_comb begin
    if (!rst_n) begin
      sp_s = sp_r;
    end else if (pop_s) begin
      sp_s = sp_r + ONE_C;
    end else begin
      sp_s = sp_r;
    end
  end

  // Read ports with optional forwarding of the value being written this cycle.
  always_comb begin
    if (addr_ok(bus.R_Add_A)) begin
      rd_a_s = reg_arr_r[bus.R_Add_A];
    end else begin
      rd_a_s = ZERO_C;
    end
    if (addr_ok(bus.R_Add_B)) begin
      rd_b_s = reg_arr_r[bus.R_Add_B];
    end else begin
      rd_b_s = ZERO_C;
    end
    if (BYPASS && bus.WrEn && (bus.R_Add_A == bus.W_Add)) begin
      rd_a_s = bus.WrData;
    end else begin
      rd_a_s = rd_a_s;
    end
    if (BYPASS && bus.WrEn && (bus.R_Add_B == bus.W_Add)) begin
      rd_b_s = bus.WrData;
    end else begin
      rd_b_s = rd_b_s;
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.Reg_A   = rd_a_s;
    bus.Reg_B   = rd_b_s;
    bus.Sp      = sp_s;
    bus.Sp_Cur  = sp_r;
    bus.Stk_Ovf = ovf_r;
    bus.Stk_Unf = unf_r;
  end

endmodule

// File: tb/tb_reg_file_stack.sv
// tb_reg_file_stack
//  Two instances (BYPASS=1 and BYPASS=0) share one stimulus stream. Each stimulus step pushes
//  the expected outputs into a queue; a monitor pops and compares every cycle.
module tb_reg_file_stack;
  localparam int W = 8;
  localparam int D = 4;
  localparam int A = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_stack_if #(.WIDTH(W), .ADDR(A)) bus1 ();
  reg_file_stack_if #(.WIDTH(W), .ADDR(A)) bus0 ();

  assign bus0.WrEn    = bus1.WrEn;
  assign bus0.W_Add   = bus1.W_Add;
  assign bus0.WrData  = bus1.WrData;
  assign bus0.R_Add_A = bus1.R_Add_A;
  assign bus0.R_Add_B = bus1.R_Add_B;
  assign bus0.IncEn   = bus1.IncEn;
  assign bus0.DecEn   = bus1.DecEn;
  assign bus0.FlagClr = bus1.FlagClr;

  reg_file_stack #(.WIDTH(W), .DEPTH(D), .ADDR(A), .SP_INIT(8'hFF), .BYPASS(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  reg_file_stack #(.WIDTH(W), .DEPTH(D), .ADDR(A), .SP_INIT(8'hFF), .BYPASS(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct {
    logic [7:0] ra1, rb1, ra0, rb0, sp, sp_cur;
    logic       ovf, unf;
    int         id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   vec_id = 0;

  // Reference model: plain arrays and modulo arithmetic.
  int m_regs[D];
  int m_sp;
  bit m_ovf, m_unf;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_regs[i] = 0;
    m_sp  = 255;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic step(input bit rst, input bit wr, input int wa, input int wd,
                      input int ra, input int rb, input bit inc, input bit dec, input bit clr);
    exp_t e;
    bit pop, push, set_o, set_u;
    @(negedge clk);
    rst_n        = rst;
    bus1.WrEn    = wr;
    bus1.W_Add   = A'(wa);
    bus1.WrData  = 8'(wd);
    bus1.R_Add_A = A'(ra);
    bus1.R_Add_B = A'(rb);
    bus1.IncEn   = inc;
    bus1.DecEn   = dec;
    bus1.FlagClr = clr;
    if (!rst) model_reset();
    pop  = inc && !dec;
    push = dec && !inc;
    e.ra1    = 8'((wr && ra == wa) ? wd : m_regs[ra]);
    e.rb1    = 8'((wr && rb == wa) ? wd : m_regs[rb]);
    e.ra0    = 8'(m_regs[ra]);
    e.rb0    = 8'(m_regs[rb]);
    e.sp     = 8'((rst && pop) ? (m_sp + 1) % 256 : m_sp);
    e.sp_cur = 8'(m_sp);
    e.ovf    = m_ovf;
    e.unf    = m_unf;
    e.id     = vec_id++;
    q.push_back(e);
    if (rst) begin
      if (wr) m_regs[wa] = wd;
      set_o = push && (m_sp == 0);
      set_u = pop && (m_sp == 255);
      m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = set_u ? 1'b1 : (clr ? 1'b0 : m_unf);
      if (pop) m_sp = (m_sp + 1) % 256;
      else if (push) m_sp = (m_sp + 255) % 256;
    end
  endtask

  task automatic idle(input int ra, input int rb);
    step(1'b1, 1'b0, 0, 0, ra, rb, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_op(input bit clr);
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1, clr);
  endtask

  task automatic pop_op();
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("reg_a_byp1", e.id, bus1.Reg_A, e.ra1);
        chk("reg_b_byp1", e.id, bus1.Reg_B, e.rb1);
        chk("reg_a_byp0", e.id, bus0.Reg_A, e.ra0);
        chk("reg_b_byp0", e.id, bus0.Reg_B, e.rb0);
        chk("sp",         e.id, bus1.Sp, e.sp);
        chk("sp_cur",     e.id, bus1.Sp_Cur, e.sp_cur);
        chk("stk_ovf",    e.id, {7'd0, bus1.Stk_Ovf}, {7'd0, e.ovf});
        chk("stk_unf",    e.id, {7'd0, bus1.Stk_Unf}, {7'd0, e.unf});
        chk("sp_byp0",    e.id, bus0.Sp_Cur, e.sp_cur);
      end
    end
  end

  initial begin
    bus1.WrEn = 1'b0; bus1.W_Add = 2'd0; bus1.WrData = 8'd0;
    bus1.R_Add_A = 2'd0; bus1.R_Add_B = 2'd0;
    bus1.IncEn = 1'b0; bus1.DecEn = 1'b0; bus1.FlagClr = 1'b0;
    model_reset();

    // Reset with enables active: state must not change across the edges.
    step(1'b0, 1'b1, 3, 8'h77, 0, 1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3, 8'h77, 2, 3, 1'b0, 1'b1, 1'b0);
    idle(0, 1);
    idle(2, 3);

    // Write 8'hA5 to r2 then read it on both ports; others stay 0.
    step(1'b1, 1'b1, 2, 8'hA5, 0, 1, 1'b0, 1'b0, 1'b0);
    idle(2, 2);
    idle(0, 3);

    // Same-cycle forwarding versus array-only read.
    step(1'b1, 1'b1, 1, 8'h3C, 1, 1, 1'b0, 1'b0, 1'b0);
    idle(1, 2);

    // Push, push, pop from FF.
    push_op(1'b0);
    push_op(1'b0);
    pop_op();

    // Walk down to 0, push to wrap and set the overflow flag, which must stick.
    while (m_sp != 0) push_op(1'b0);
    push_op(1'b0);
    idle(0, 0); idle(0, 0); idle(0, 0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(0, 0);
    // Pop from FF wraps to 0 and sets underflow.
    pop_op();
    idle(0, 0);
    // Clear together with a new overflow: overflow set wins, underflow clears.
    push_op(1'b1);
    idle(0, 0);

    // Both enables at SP=80: hold, no flag.
    while (m_sp != 8'h80) push_op(1'b0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    idle(0, 0);
    // Reset between two pushes.
    push_op(1'b0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    push_op(1'b0);
    idle(0, 0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle(0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", vec_id, 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
